// File: rtl/snd_i2s_tx.sv
// I2S transmitter: serializes 16-bit stereo samples from shadow registers into
// a standard I2S stream. BCLK and LRCK are derived from CLK and one SMPL_REQ
// pulse is issued per frame, when the shadow registers reload.
module snd_i2s_tx #(
  parameter int BCLK_DIV  = 4,
  parameter int SLOT_BITS = 32
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic [15:0] L_BUFF,
  input  logic [15:0] R_BUFF,
  output logic        SMPL_REQ,
  output logic        I2S_BCLK,
  output logic        I2S_LRCK,
  output logic        I2S_SDATA
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_BITS);
  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_TC = BIT_W'(2 * SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_C = BIT_W'(SLOT_BITS);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               bclk_q, bclk_d;
  logic               lrck_q, lrck_d;
  logic               sdata_q, sdata_d;
  logic               req_q, req_d;
  logic [15:0]        l_sh_q, l_sh_d;
  logic [15:0]        r_sh_q, r_sh_d;
  logic [BIT_W-1:0]   slot_pos;
  logic [15:0]        word;

  // Next-state logic: divider, falling-edge bit advance, frame-boundary reload.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    bclk_d    = bclk_q;
    lrck_d    = lrck_q;
    sdata_d   = sdata_q;
    req_d     = 1'b0;
    l_sh_d    = l_sh_q;
    r_sh_d    = r_sh_q;
    slot_pos  = '0;
    word      = l_sh_q;
    case (state_q)
      S_IDLE: begin
        div_cnt_d = '0;
        bit_cnt_d = '0;
        bclk_d    = 1'b0;
        lrck_d    = 1'b0;
        sdata_d   = 1'b0;
        if (EN) begin
          state_d = S_RUN;
          l_sh_d  = L_BUFF;
          r_sh_d  = R_BUFF;
          req_d   = 1'b1;
        end
      end
      S_RUN: begin
        if (div_cnt_q != DIV_TC) begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end else begin
          div_cnt_d = '0;
          bclk_d    = ~bclk_q;
          // Everything else only moves on the BCLK falling edge.
          if (bclk_q) begin
            if (bit_cnt_q == BIT_TC) begin
              bit_cnt_d = '0;
              lrck_d    = 1'b0;
              sdata_d   = 1'b0;
              if (EN) begin
                l_sh_d = L_BUFF;
                r_sh_d = R_BUFF;
                req_d  = 1'b1;
              end else begin
                state_d = S_IDLE;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
              lrck_d    = (bit_cnt_d >= SLOT_C);
              slot_pos  = lrck_d ? (bit_cnt_d - SLOT_C) : bit_cnt_d;
              word      = lrck_d ? r_sh_q : l_sh_q;
              // Position 0 of each slot is the one-BCLK MSB delay; past 16 is padding.
              if ((slot_pos != '0) && (slot_pos <= BIT_W'(16)))
                sdata_d = word[4'(5'd16 - 5'(slot_pos))];
              else
                sdata_d = 1'b0;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      bclk_q    <= 1'b0;
      lrck_q    <= 1'b0;
      sdata_q   <= 1'b0;
      req_q     <= 1'b0;
      l_sh_q    <= '0;
      r_sh_q    <= '0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      bclk_q    <= bclk_d;
      lrck_q    <= lrck_d;
      sdata_q   <= sdata_d;
      req_q     <= req_d;
      l_sh_q    <= l_sh_d;
      r_sh_q    <= r_sh_d;
    end
  end

  assign SMPL_REQ  = req_q;
  assign I2S_BCLK  = bclk_q;
  assign I2S_LRCK  = lrck_q;
  assign I2S_SDATA = sdata_q;

endmodule

// File: tb/tb_snd_i2s_tx.sv
// Bench for snd_i2s_tx: a default instance (DIV=4, SLOT=32) and an extreme one
// (DIV=1, SLOT=17), checked every cycle against a time-since-frame-start model
// plus literal frame/timing expectations.
module tb_snd_i2s_tx;

  localparam int DIVP [2] = '{4, 1};
  localparam int SP   [2] = '{32, 17};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en      [2];
  logic [15:0] lb      [2];
  logic [15:0] rb      [2];
  logic        req_o   [2];
  logic        bclk_o  [2];
  logic        lrck_o  [2];
  logic        sdata_o [2];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // model state: running flag, cycles since frame start, captured samples
  bit          m_run [2] = '{0, 0};
  int          m_t   [2] = '{0, 0};
  bit          m_req [2] = '{0, 0};
  logic [15:0] m_l   [2] = '{16'h0, 16'h0};
  logic [15:0] m_r   [2] = '{16'h0, 16'h0};

  // monitor state
  int          req_cnt     [2] = '{0, 0};
  int          last_req    [2] = '{0, 0};
  int          req_gap     [2] = '{0, 0};
  int          last_lr     [2] = '{0, 0};
  int          lr_gap      [2] = '{0, 0};
  int          ncap        [2] = '{0, 0};
  int          frames_done [2] = '{0, 0};
  logic [63:0] cap         [2] = '{64'h0, 64'h0};
  logic [63:0] lcap        [2] = '{64'h0, 64'h0};
  logic [63:0] frame_last  [2] = '{64'h0, 64'h0};
  logic [63:0] lr_last     [2] = '{64'h0, 64'h0};
  logic        prev_bclk   [2] = '{1'b0, 1'b0};
  logic        prev_lrck   [2] = '{1'b0, 1'b0};

  snd_i2s_tx #(.BCLK_DIV(4), .SLOT_BITS(32)) u_dut_def (
    .CLK(clk), .RST(rst), .EN(en[0]), .L_BUFF(lb[0]), .R_BUFF(rb[0]),
    .SMPL_REQ(req_o[0]), .I2S_BCLK(bclk_o[0]), .I2S_LRCK(lrck_o[0]), .I2S_SDATA(sdata_o[0])
  );

  snd_i2s_tx #(.BCLK_DIV(1), .SLOT_BITS(17)) u_dut_ext (
    .CLK(clk), .RST(rst), .EN(en[1]), .L_BUFF(lb[1]), .R_BUFF(rb[1]),
    .SMPL_REQ(req_o[1]), .I2S_BCLK(bclk_o[1]), .I2S_LRCK(lrck_o[1]), .I2S_SDATA(sdata_o[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected {SMPL_REQ, BCLK, LRCK, SDATA} from time within the frame.
  function automatic logic [3:0] exp_out(input int d);
    int n, k;
    logic [15:0] s;
    logic b, l, sd;
    if (!m_run[d]) return 4'b0000;
    n  = m_t[d] / (2 * DIVP[d]);
    k  = n % SP[d];
    l  = (n >= SP[d]);
    s  = l ? m_r[d] : m_l[d];
    b  = ((m_t[d] / DIVP[d]) % 2) == 1;
    sd = (k >= 1 && k <= 16) ? s[16 - k] : 1'b0;
    return {m_req[d], b, l, sd};
  endfunction

  // Model update: frames last 2*SLOT BCLKs, EN/inputs only sampled at entry or frame end.
  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_run[d] = 0; m_t[d] = 0; m_req[d] = 0;
      end else if (!m_run[d]) begin
        m_req[d] = 0;
        if (en[d]) begin
          m_run[d] = 1; m_t[d] = 0; m_l[d] = lb[d]; m_r[d] = rb[d]; m_req[d] = 1;
        end
      end else begin
        m_req[d] = 0;
        m_t[d]++;
        if (m_t[d] == 4 * SP[d] * DIVP[d]) begin
          m_t[d] = 0;
          if (en[d]) begin
            m_l[d] = lb[d]; m_r[d] = rb[d]; m_req[d] = 1;
          end else begin
            m_run[d] = 0;
          end
        end
      end
    end
  end

  // Per-cycle compare plus bit capture on BCLK rise.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [3:0] act, ex;
      act = {req_o[d], bclk_o[d], lrck_o[d], sdata_o[d]};
      ex  = exp_out(d);
      vectors++;
      if (act !== ex) begin
        miscompares++;
        $display("FAIL cycle_outputs dut%0d cyc=%0d t=%0d got={req,bclk,lrck,sd}=%b want=%b",
                 d, cyc, m_t[d], act, ex);
      end
      if (req_o[d]) begin
        req_cnt[d]++;
        req_gap[d] = cyc - last_req[d];
        last_req[d] = cyc;
        ncap[d] = 0; cap[d] = '0; lcap[d] = '0;
      end
      if (bclk_o[d] && !prev_bclk[d]) begin
        cap[d]  = {cap[d][62:0], sdata_o[d]};
        lcap[d] = {lcap[d][62:0], lrck_o[d]};
        ncap[d]++;
        if (ncap[d] == 2 * SP[d]) begin
          frame_last[d] = cap[d];
          lr_last[d] = lcap[d];
          frames_done[d]++;
        end
      end
      if (lrck_o[d] != prev_lrck[d]) begin
        lr_gap[d] = cyc - last_lr[d];
        last_lr[d] = cyc;
      end
      prev_bclk[d] = bclk_o[d];
      prev_lrck[d] = lrck_o[d];
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endtask

  task automatic wait_for(input string name, input int d, input bit frames, input int target,
                          input int limit);
    int n;
    n = 0;
    while (((frames ? frames_done[d] : req_cnt[d]) < target) && n < limit) begin
      tick();
      n++;
    end
    vectors++;
    if ((frames ? frames_done[d] : req_cnt[d]) < target) begin
      miscompares++;
      $display("FAIL %s: timeout after %0d cycles, count %0d want %0d", name, n,
               frames ? frames_done[d] : req_cnt[d], target);
    end
  endtask

  function automatic logic [63:0] frame64(input logic [15:0] l, input logic [15:0] r);
    return {1'b0, l, 15'h0, 1'b0, r, 15'h0};
  endfunction

  initial begin
    en[0] = 1'b1; lb[0] = 16'hFFFF; rb[0] = 16'hFFFF;
    en[1] = 1'b0; lb[1] = 16'h0;    rb[1] = 16'h0;
    rst = 1'b1;

    // Reset held with EN=1: quiet outputs, no requests.
    repeat (20) tick();
    chk("reset_outputs", {60'h0, req_o[0], bclk_o[0], lrck_o[0], sdata_o[0]}, 64'h0);
    chk("reset_no_req", 64'(req_cnt[0]), 64'd0);

    // Basic frames.
    lb[0] = 16'hA5C3; rb[0] = 16'h0F81;
    rst = 1'b0;
    tick();
    chk("first_req_after_en", {63'h0, req_o[0]}, 64'h1);
    wait_for("frame1", 0, 1, 1, 600);
    chk("frame1_data", frame_last[0], frame64(16'hA5C3, 16'h0F81));
    chk("frame1_lrck", lr_last[0], {32'h0, 32'hFFFF_FFFF});
    wait_for("req2", 0, 0, 2, 100);
    chk("req_period_512", 64'(req_gap[0]), 64'd512);

    // Mid-frame input change never touches the frame in flight.
    lb[0] = 16'h1234;
    wait_for("frame2", 0, 1, 2, 600);
    chk("frame2_data", frame_last[0], frame64(16'hA5C3, 16'h0F81));
    chk("lrck_half_frame", 64'(lr_gap[0]), 64'd256);
    wait_for("req3", 0, 0, 3, 100);
    repeat (100) tick();
    lb[0] = 16'h8000;
    wait_for("frame3", 0, 1, 3, 600);
    chk("frame3_data", frame_last[0], frame64(16'h1234, 16'h0F81));

    // EN glitch within a frame has no effect.
    wait_for("req4", 0, 0, 4, 100);
    repeat (150) tick();
    en[0] = 1'b0;
    repeat (10) tick();
    en[0] = 1'b1;
    wait_for("frame4", 0, 1, 4, 600);
    chk("frame4_data", frame_last[0], frame64(16'h8000, 16'h0F81));

    // Stop: frame completes, then idle with no further requests.
    wait_for("req5", 0, 0, 5, 100);
    chk("req_period_after_glitch", 64'(req_gap[0]), 64'd512);
    repeat (200) tick();
    en[0] = 1'b0;
    wait_for("frame5", 0, 1, 5, 600);
    chk("frame5_data", frame_last[0], frame64(16'h8000, 16'h0F81));
    repeat (600) tick();
    chk("stop_no_req", 64'(req_cnt[0]), 64'd5);
    chk("stop_idle_outputs", {60'h0, req_o[0], bclk_o[0], lrck_o[0], sdata_o[0]}, 64'h0);

    // Restart.
    en[0] = 1'b1;
    wait_for("req6", 0, 0, 6, 10);
    wait_for("frame6", 0, 1, 6, 600);
    chk("frame6_data", frame_last[0], frame64(16'h8000, 16'h0F81));

    // Async reset mid-frame.
    wait_for("req7", 0, 0, 7, 100);
    repeat (300) tick();
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", {60'h0, req_o[0], bclk_o[0], lrck_o[0], sdata_o[0]}, 64'h0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("post_reset_req", {62'h0, req_o[0], lrck_o[0]}, 64'h2);
    wait_for("frame8", 0, 1, 7, 600);
    chk("frame8_data", frame_last[0], frame64(16'h8000, 16'h0F81));
    chk("req_total", 64'(req_cnt[0]), 64'd8);
    en[0] = 1'b0;

    // Extreme parameters on the second instance.
    lb[1] = 16'h7FFF; rb[1] = 16'h8000; en[1] = 1'b1;
    wait_for("ext_frame1", 1, 1, 1, 200);
    chk("ext_frame1_data", frame_last[1], {30'h0, 1'b0, 16'h7FFF, 1'b0, 16'h8000});
    chk("ext_frame1_lrck", lr_last[1], {30'h0, 17'h0, 17'h1FFFF});
    wait_for("ext_frame2", 1, 1, 2, 200);
    chk("ext_req_period_68", 64'(req_gap[1]), 64'd68);
    chk("ext_lrck_period_34", 64'(lr_gap[1]), 64'd34);
    en[1] = 1'b0;
    repeat (200) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
